// File: rtl/alu_mc_if.sv
// alu_mc_if: operand/function issue channel and result/flag channel for alu_mc.
// master = issuer/consumer side, slave = the ALU.
interface alu_mc_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [5:0]   ALUfn;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] R;
  logic         FlagZ;
  logic         FlagN;
  logic         FlagC;
  logic         FlagV;
  logic         busy;

  modport master (
    output in_valid, A, B, ALUfn, out_ready,
    input  in_ready, out_valid, R, FlagZ, FlagN, FlagC, FlagV, busy
  );

  modport slave (
    input  in_valid, A, B, ALUfn, out_ready,
    output in_ready, out_valid, R, FlagZ, FlagN, FlagC, FlagV, busy
  );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: handshaked ALU with registered result and Z/N/C/V flags.
// Define ALU_MC_MUL_EN to add the iterative N-cycle shift-add multiplier.
module alu_mc #(
  parameter int N = 32
) (
  input  logic    clock,
  input  logic    reset_n,
  alu_mc_if.slave bus
);
  // state | meaning
  // IDLE  | accepting ops; single-cycle results load on the accept edge
  // MUL   | multiplier iterating, counter runs 0..N-1

  localparam int SW = $clog2(N);

  logic [N-1:0] r_q;
  logic         z_q, n_q, c_q, v_q;
  logic         out_valid_q;
  logic         in_ready_c;
  logic         accept;

  logic         math, shft, bool1, bool0, sub_eff;
  logic [N-1:0] b_eff, sum, alu_r;
  logic [N:0]   sum_ext;
  logic         cout, ovf, lt, alu_c, alu_v;
  logic [SW-1:0] shamt;

  assign math  = bus.ALUfn[0];
  assign shft  = bus.ALUfn[1];
  assign bool0 = bus.ALUfn[2];
  assign bool1 = bus.ALUfn[3];
  // compare always subtracts, whatever the subtract bit says
  assign sub_eff = bus.ALUfn[4] | (shft & math);
  assign b_eff   = sub_eff ? ~bus.B : bus.B;
  assign sum_ext = {1'b0, bus.A} + {1'b0, b_eff} + {{N{1'b0}}, sub_eff};
  assign sum     = sum_ext[N-1:0];
  assign cout    = sum_ext[N];
  assign ovf     = (bus.A[N-1] == b_eff[N-1]) && (sum[N-1] != bus.A[N-1]);
  assign lt      = bool0 ? ~cout : (sum[N-1] ^ ovf);
  assign shamt   = bus.A[SW-1:0];
  assign alu_c   = math ? cout : 1'b0;
  assign alu_v   = math ? ovf : 1'b0;

  always_comb begin
    alu_r = '0;
    case ({shft, math})
      2'b01: alu_r = sum;
      2'b10: begin
        if (!bool1)      alu_r = bus.B << shamt;
        else if (!bool0) alu_r = bus.B >> shamt;
        else             alu_r = $signed(bus.B) >>> shamt;
      end
      2'b00: begin
        case ({bool1, bool0})
          2'b00:   alu_r = bus.A & bus.B;
          2'b01:   alu_r = bus.A | bus.B;
          2'b10:   alu_r = bus.A ^ bus.B;
          default: alu_r = ~(bus.A | bus.B);
        endcase
      end
      default: alu_r = {{(N-1){1'b0}}, lt};
    endcase
  end

  assign accept = bus.in_valid && in_ready_c;

`ifdef ALU_MC_MUL_EN
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, MUL} state_t;
  state_t        state;
  logic [N-1:0]  acc, mcand, mplier, acc_next;
  logic [CW-1:0] cnt;
  logic          busy_q;

  assign acc_next   = acc + (mplier[0] ? mcand : '0);
  assign in_ready_c = (state == IDLE) && (!out_valid_q || bus.out_ready);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      cnt         <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      r_q         <= '0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
    end else begin
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (bus.ALUfn[5]) begin
              state  <= MUL;
              acc    <= '0;
              mcand  <= bus.A;
              mplier <= bus.B;
              cnt    <= '0;
              busy_q <= 1'b1;
            end else begin
              r_q         <= alu_r;
              z_q         <= ~|alu_r;
              n_q         <= alu_r[N-1];
              c_q         <= alu_c;
              v_q         <= alu_v;
              out_valid_q <= 1'b1;
            end
          end
        end
        default: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (cnt == LAST) begin
            state       <= IDLE;
            cnt         <= '0;
            busy_q      <= 1'b0;
            r_q         <= acc_next;
            z_q         <= ~|acc_next;
            n_q         <= acc_next[N-1];
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
`else
  logic unused_mul_sel;
  assign unused_mul_sel = bus.ALUfn[5];
  assign in_ready_c     = !out_valid_q || bus.out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      r_q         <= '0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
    end else if (accept) begin
      r_q         <= alu_r;
      z_q         <= ~|alu_r;
      n_q         <= alu_r[N-1];
      c_q         <= alu_c;
      v_q         <= alu_v;
      out_valid_q <= 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.busy = 1'b0;
`endif

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.R         = r_q;
  assign bus.FlagZ     = z_q;
  assign bus.FlagN     = n_q;
  assign bus.FlagC     = c_q;
  assign bus.FlagV     = v_q;
endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, handshaked successor to the combinational datapath ALU. It keeps the 5-bit function encoding for add/sub, shift, logical and compare, and adds registered results and a full flag set (Z, N, C, V). It also adds valid/ready flow control on both sides and an optional iterative N-cycle multiplier. It sits between the decode/operand-fetch stage and writeback of the multi-cycle core, so a stalled consumer back-pressures the issuer.

## Interface
- N, 32, operand/result width; N ≥ 4, power of two
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands and function are valid
- in_ready  out  1  block accepts this cycle; transfer when in_valid && in_ready
- A, B  in  N  operands; the shift amount is A[$clog2(N)-1:0] and the shifted value is B
- ALUfn  in  6  ALUfn[5] = mul; ALUfn[4:0] = {subtract, bool1, bool0, shft, math}
- out_valid  out  1  R and the flags hold a result
- out_ready  in  1  consumer takes the result; transfer when out_valid && out_ready
- R  out  N  registered result
- FlagZ, FlagN, FlagC, FlagV  out  1 each  registered flags for R
- busy  out  1  multiplier iterating

## Operation
Decode when ALUfn[5] = 0:
- **{shft, math} = 01, add/sub:** R = A + B when subtract = 0, or A + ~B + 1 when subtract = 1. C = carry-out of the N-bit sum. V = signed overflow.
- **{shft, math} = 10, shift:**
  - bool1 = 0 → SLL.
  - {bool1, bool0} = 10 → SRL.
  - {bool1, bool0} = 11 → SRA.
  - Shift amount is modulo N.
- **{shft, math} = 00, logical:** {bool1, bool0} = 00 AND, 01 OR, 10 XOR, 11 NOR.
- **{shft, math} = 11, compare:** the internal subtraction A − B is forced regardless of the subtract bit. R = {N-1 zeros, lt}.
  - bool0 = 0 → signed: lt = N ^ V.
  - bool0 = 1 → unsigned: lt = ~C.
- **Flags:** FlagZ = ~|R and FlagN = R[N-1] for every op. FlagC and FlagV come from the adder for add/sub/compare and are 0 for shift and logical.

Multiply (ALUfn[5] = 1, macro enabled):
- Unsigned shift-add multiply; R = low N bits of A*B. ALUfn[4:0] is ignored.
- Each cycle: acc += mcand if mplier[0]; mcand <<= 1; mplier >>= 1.
- Iteration counter is $clog2(N)+1 bits and runs exactly N iterations, with no early exit.
- Flags: FlagC = FlagV = 0; FlagZ and FlagN follow R.

FSM states IDLE and MUL:
- IDLE → MUL on accepting a multiply.
- MUL → IDLE when the counter reaches N−1. The product and flags load into the output register on that edge and out_valid is set.
- A single-cycle op stays in IDLE and loads the output register on the accepting edge.

Handshake:
- in_ready = (state == IDLE) && (!out_valid || out_ready).
- out_valid clears on an output transfer, unless a new result loads on the same edge, in which case it stays 1.
- While out_valid && !out_ready, R and the flags hold stable.
- Back-to-back single-cycle ops with out_ready held at 1 sustain one result per cycle.

## Timing
- **Reset (asynchronous assert):** state = IDLE, out_valid = 0, R = 0, all flags = 0, busy = 0, counter = 0. in_ready = 1 after reset.
- **Reset mid-multiply:** aborts the operation, discards the partial product, and produces no out_valid pulse.
- **Single-cycle op:** accepted at edge k → out_valid = 1 after edge k, latency 1.
- **Multiply:**
  - Accepted at edge k → out_valid = 1 after edge k+N.
  - busy = 1 and in_ready = 0 during cycles k+1 .. k+N.
  - in_ready returns to 1 after edge k+N only if out_ready = 1.
- **Simultaneous output drain and new accept:** the new result replaces the old one with no bubble.
- **in_valid while in_ready = 0:** ignored; the issuer holds its inputs.
- **Counter:** no wrap-around beyond N−1; it returns to 0 on leaving MUL.

## Configuration
- **ALU_MC_MUL_EN defined:** multiplier datapath, counter and MUL state are present; behaviour is as above.
- **ALU_MC_MUL_EN undefined:**
  - ALUfn[5] is ignored and every op is single-cycle, decoded from ALUfn[4:0].
  - busy is tied to 0 and no multiplier registers are synthesised.

## Test plan
- **ADD:** A = 0x7FFFFFFF, B = 1, ALUfn = 000001 → R = 0x80000000, N = 1, V = 1, C = 0, Z = 0, out_valid one cycle after accept.
- **SUB:** A = 5, B = 5, ALUfn = 010001 → R = 0, Z = 1, C = 1, V = 0.
- **Compare:**
  - A = 0xFFFFFFFF, B = 1, ALUfn = 010011 (signed) → R = 1.
  - Same operands, ALUfn = 010111 (unsigned) → R = 0.
- **SRA:** B = 0x80000000, A = 4, ALUfn = 001110 → R = 0xF8000000, C = V = 0.
- **MUL (macro on):** A = 0x00010000, B = 0x00010001, ALUfn = 100000 → R = 0x00010000 exactly 32 cycles after accept. busy = 1 and in_ready = 0 throughout.
- **Back-pressure and reset:**
  - Hold out_ready = 0 for 5 cycles after a result → R and flags stable, in_ready = 0.
  - Assert reset_n = 0 at cycle 10 of a multiply → out_valid = 0, in_ready = 1, no result emitted.
